// File: rtl/pll_reset_sequencer.sv
// Supervises an SB_PLL40_CORE from the 12 MHz reference domain: drives RESETB, qualifies LOCK,
// releases the fast-clock domain reset, retries failed attempts and latches a fault.
module pll_reset_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_resetb,
    output logic       domain_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLL_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       C_MAX_RTY  = 4'(MAX_RETRIES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_sync2;
    logic [3:0]       r_retry;
    logic [7:0]       r_loss;
    logic [3:0]       r_outs;   // {pll_resetb, domain_reset_n, ready, fault}
    logic             w_lock_s;
    logic [3:0]       w_retry_inc;

    assign w_lock_s    = r_sync2;
    assign w_retry_inc = r_retry + 4'd1;

    // Outputs are registered alongside the state, so they are a pure function of the next state.
    function automatic logic [3:0] outs_for(state_t s);
        case (s)
            S_WAIT_LOCK, S_STABLE: return 4'b1000;
            S_RUN:                 return 4'b1110;
            S_FAULT:               return 4'b0001;
            default:               return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_retry <= '0;
            r_loss  <= '0;
            r_outs  <= '0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
            if (!enable) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_retry <= '0;
                r_outs  <= outs_for(S_IDLE);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_retry <= '0;
                        r_cnt   <= '0;
                        r_state <= S_PLL_RST;
                        r_outs  <= outs_for(S_PLL_RST);
                    end
                    S_PLL_RST: begin
                        if (r_cnt == C_RST_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_WAIT_LOCK;
                            r_outs  <= outs_for(S_WAIT_LOCK);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_WAIT_LOCK: begin
                        // Lock seen on the timeout cycle still counts as a success.
                        if (w_lock_s) begin
                            r_cnt   <= '0;
                            r_state <= S_STABLE;
                            r_outs  <= outs_for(S_STABLE);
                        end else if (r_cnt == C_TO_LAST) begin
                            r_cnt   <= '0;
                            r_retry <= w_retry_inc;
                            if (w_retry_inc == C_MAX_RTY) begin
                                r_state <= S_FAULT;
                                r_outs  <= outs_for(S_FAULT);
                            end else begin
                                r_state <= S_PLL_RST;
                                r_outs  <= outs_for(S_PLL_RST);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_STABLE: begin
                        if (!w_lock_s) begin
                            r_cnt   <= '0;
                            r_state <= S_WAIT_LOCK;
                            r_outs  <= outs_for(S_WAIT_LOCK);
                        end else if (r_cnt == C_STB_LAST) begin
                            r_cnt   <= '0;
                            r_retry <= '0;
                            r_state <= S_RUN;
                            r_outs  <= outs_for(S_RUN);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (!w_lock_s) begin
                            if (r_loss != 8'hFF) begin
                                r_loss <= r_loss + 8'd1;
                            end
                            r_cnt   <= '0;
                            r_state <= S_PLL_RST;
                            r_outs  <= outs_for(S_PLL_RST);
                        end
                    end
                    S_FAULT: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_outs  <= outs_for(S_IDLE);
                    end
                endcase
            end
        end
    end

    assign pll_resetb      = r_outs[3];
    assign domain_reset_n  = r_outs[2];
    assign ready           = r_outs[1];
    assign fault           = r_outs[0];
    assign retry_count     = r_retry;
    assign lock_loss_count = r_loss;
    assign state           = r_state;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Supervises the iCE40 `SB_PLL40_CORE` clock wrappers (12 MHz in, fast clock out) from the 12 MHz reference domain.
- Drives the PLL's RESETB and qualifies its raw LOCK output with a synchronizer and a stability window.
- Releases a registered reset for the downstream fast-clock logic; that logic re-synchronizes it locally.
- Retries failed lock attempts, counts lock losses, and latches a fault after too many failed attempts.

## Interface
Parameters:
- `RESET_CYCLES`, 16, cycles RESETB is held low per attempt (≥1)
- `LOCK_TIMEOUT`, 4096, cycles allowed per attempt to see lock (≥1)
- `STABLE_CYCLES`, 256, consecutive locked cycles required before release (≥1)
- `MAX_RETRIES`, 3, failed attempts before FAULT (1..15)
- `CNT_W`, 16, shared counter width; must hold max of the three cycle parameters

Ports:
- `clock_in` in 1: 12 MHz reference clock, the same net feeding the PLL; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: request to run the PLL; level-sensitive.
- `pll_locked` in 1: raw PLL LOCK; asynchronous.
- `pll_resetb` out 1: to the PLL RESETB pin.
- `domain_reset_n` out 1: active-low reset for the fast-clock domain.
- `ready` out 1: PLL qualified and domain released.
- `fault` out 1: retries exhausted.
- `retry_count` out 4: failed attempts in the current enable session.
- `lock_loss_count` out 8: lock drops seen in RUN; saturates at 255.
- `state` out 3: current FSM state, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `lock_s`; all decisions use `lock_s`.
- A single counter `cnt` (CNT_W bits) clears on every state change.
- FSM states, with the `state` encoding:
  - IDLE=0
  - PLL_RST=1
  - WAIT_LOCK=2
  - STABLE=3
  - RUN=4
  - FAULT=5
- `enable`=0 in any state forces IDLE on the next edge. This has priority over every other transition.
- **IDLE:** clears `retry_count`. If `enable`=1 → PLL_RST.
- **PLL_RST:** `cnt` increments. When `cnt`==RESET_CYCLES-1 → WAIT_LOCK.
- **WAIT_LOCK:** `cnt` increments.
  - `lock_s`=1 → STABLE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT-1, `retry_count` increments. If the new value ==MAX_RETRIES → FAULT, else → PLL_RST.
- **STABLE:** `cnt` increments.
  - `lock_s`=0 → WAIT_LOCK. The timeout restarts and `retry_count` does not change.
  - `cnt`==STABLE_CYCLES-1 with `lock_s`=1 → RUN, and `retry_count` clears.
- **RUN:** `lock_s`=0 → PLL_RST, and `lock_loss_count` increments (saturating at 255).
- **FAULT:** hold until `enable`=0.
- Outputs are registered and depend only on the current state:
  - `pll_resetb`=1 only in WAIT_LOCK, STABLE and RUN.
  - `domain_reset_n`=1 and `ready`=1 only in RUN.
  - `fault`=1 only in FAULT.
- `lock_loss_count` is cleared only by `reset_n`.

## Timing
- Values during reset:
  - state IDLE
  - `pll_resetb`=0, `domain_reset_n`=0, `ready`=0, `fault`=0
  - `retry_count`=0, `lock_loss_count`=0
  - synchronizer flops 0
- `reset_n` asserted mid-operation forces these values immediately (asynchronously). Release is synchronous to `clock_in`.
- Reset sequence timing:
  - With `enable` high at edge E, state is PLL_RST after E.
  - `pll_resetb` is low for exactly RESET_CYCLES cycles in PLL_RST.
  - `pll_resetb` rises after edge E+RESET_CYCLES.
- Lock qualification timing:
  - The first edge sampling `pll_locked`=1 is edge K.
  - `lock_s`=1 after K+1, and STABLE is entered after K+2.
  - `ready`/`domain_reset_n` rise after K+2+STABLE_CYCLES, provided lock holds.
- Lock loss: from `pll_locked` falling (sampled at edge L), `domain_reset_n` is low after L+2 and `pll_resetb` is low in the same cycle.
- Timeout: an attempt with no lock spends exactly LOCK_TIMEOUT cycles in WAIT_LOCK.
- Simultaneous events:
  - `lock_s`=1 on the timeout cycle of WAIT_LOCK: lock wins → STABLE.
  - `enable`=0 at the same edge as any event: → IDLE, and no counters change except the `retry_count` clear.

## Test plan
Parameters for all cases: RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Nominal:** assert `enable`; the PLL model raises lock 10 cycles after `pll_resetb` rises.
  - `pll_resetb` low for 4 cycles.
  - `ready`=`domain_reset_n`=1 exactly 10 cycles after the edge where lock is first sampled.
  - `retry_count`=0.
- **Lock glitch:** lock high for 5 cycles, low for 1, then high.
  - Returns to WAIT_LOCK; `ready` is delayed a full 8-cycle window after the re-lock; `retry_count` unchanged.
- **Timeouts:** lock never rises.
  - Two 32-cycle WAIT_LOCK windows, each preceded by 4 cycles of `pll_resetb` low.
  - Then `fault`=1, `retry_count`=2, `pll_resetb`=0.
  - Dropping `enable` → IDLE and `retry_count`=0.
- **Lock loss in RUN:** drop lock at edge L.
  - `domain_reset_n`=0 after L+2; `lock_loss_count`=1; re-sequence reaches RUN again.
  - After 256 drops, `lock_loss_count` stays at 255.
- **Async reset:** pulse `reset_n` low for half a cycle while in STABLE.
  - All outputs return to their reset values immediately.
  - With `enable` still high after release, the sequence restarts at PLL_RST.
- **Priority:** deassert `enable` on the same edge that WAIT_LOCK times out.
  - → IDLE; `retry_count`=0; `fault` never asserts.
